// File: rtl/c7bexu_lsu_pkg.sv
// Shared definitions for the c7bexu load/store unit: op field layout,
// access size encodings and the FSM state type.
package c7bexu_lsu_pkg;

    // Op vector layout: {store, unsigned, size[1:0]}
    localparam int OP_W        = 4;
    localparam int OP_STORE    = 3;
    localparam int OP_UNSIGNED = 2;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_RSV = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LS1  = 2'd1,
        ST_RSP  = 2'd2,
        ST_LS3  = 2'd3
    } lsu_state_e;

    function automatic lsu_size_e op_size(input logic [OP_W-1:0] op);
        return lsu_size_e'(op[1:0]);
    endfunction

endpackage

// File: rtl/c7bexu_lsu_if.sv
// Memory bus between the LSU (master) and the memory side (slave):
// a valid/ready request channel and a single-cycle response pulse.
interface c7bexu_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              lsu_bus_req_valid;
    logic              lsu_bus_req_ready;
    logic              lsu_bus_req_we;
    logic [ADDR_W-1:0] lsu_bus_req_addr;
    logic [3:0]        lsu_bus_req_wstrb;
    logic [DATA_W-1:0] lsu_bus_req_wdata;
    logic              lsu_bus_rsp_valid;
    logic [DATA_W-1:0] lsu_bus_rsp_rdata;
    logic              lsu_bus_rsp_err;
    logic              lsu_bus_rsp_ecc_err;

    modport master (
        output lsu_bus_req_valid, lsu_bus_req_we, lsu_bus_req_addr,
               lsu_bus_req_wstrb, lsu_bus_req_wdata,
        input  lsu_bus_req_ready, lsu_bus_rsp_valid, lsu_bus_rsp_rdata,
               lsu_bus_rsp_err, lsu_bus_rsp_ecc_err
    );

    modport slave (
        input  lsu_bus_req_valid, lsu_bus_req_we, lsu_bus_req_addr,
               lsu_bus_req_wstrb, lsu_bus_req_wdata,
        output lsu_bus_req_ready, lsu_bus_rsp_valid, lsu_bus_rsp_rdata,
               lsu_bus_rsp_err, lsu_bus_rsp_ecc_err
    );
endinterface

// File: rtl/c7bexu_lsu_align.sv
// Combinational alignment helper: misalignment detection, store byte-lane
// strobes/replication, and load byte/half selection with extension.
module c7bexu_lsu_align
    import c7bexu_lsu_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [31:0]     wdata_i,
    input  logic [31:0]     rdata_i,
    output logic            ale_o,
    output logic [3:0]      wstrb_o,
    output logic [31:0]     wdata_o,
    output logic [31:0]     rdata_o
);

    lsu_size_e   size;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic        uns;

    // Decode size into alignment check, lane strobes and extended load data
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        size    = op_size(op_i);
        uns     = op_i[OP_UNSIGNED];
        sel_b   = rdata_i[{addr_lo_i, 3'b000} +: 8];
        sel_h   = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        ale_o   = 1'b0;
        wstrb_o = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        unique case (size)
            SZ_B: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = uns ? {24'd0, sel_b} : {{24{sel_b[7]}}, sel_b};
            end
            SZ_H: begin
                ale_o   = addr_lo_i[0];
                wstrb_o = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = uns ? {16'd0, sel_h} : {{16{sel_h[15]}}, sel_h};
            end
            SZ_W: begin
                ale_o   = |addr_lo_i;
                wstrb_o = 4'b1111;
            end
            SZ_RSV: begin
                ale_o   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/c7bexu_lsu.sv
// c7bexu load/store unit: latches one E-stage op, checks alignment in LS1,
// runs one bus transaction and returns a single completion/exception pulse
// in LS3. One op outstanding at a time.
module c7bexu_lsu
    import c7bexu_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              lsu_vld_e,
    input  logic [OP_W-1:0]   lsu_op_e,
    input  logic [ADDR_W-1:0] lsu_addr_e,
    input  logic [DATA_W-1:0] lsu_wdata_e,
    output logic              lsu_except_ale_ls1,
    output logic              lsu_except_buserr_ls3,
    output logic              lsu_except_ecc_ls3,
    output logic              lsu_data_valid_ls3,
    output logic              lsu_wr_fin_ls3,
    output logic [DATA_W-1:0] lsu_rdata_ls3,
    c7bexu_lsu_if.master      bus
);

    lsu_state_e        state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q, ecc_q;

    logic              cap_e, cap_rsp;
    logic              req_valid;
    logic              ale_w;
    logic [3:0]        strb_w;
    logic [DATA_W-1:0] lane_wdata_w, ext_rdata_w;
    logic              is_store;

    assign is_store = op_q[OP_STORE];

    c7bexu_lsu_align u_align (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (rdata_q),
        .ale_o     (ale_w),
        .wstrb_o   (strb_w),
        .wdata_o   (lane_wdata_w),
        .rdata_o   (ext_rdata_w)
    );

    // State register plus E-stage and response capture registers
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!resetn) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ecc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cap_e) begin
                op_q    <= lsu_op_e;
                addr_q  <= lsu_addr_e;
                wdata_q <= lsu_wdata_e;
            end
            if (cap_rsp) begin
                rdata_q <= bus.lsu_bus_rsp_rdata;
                err_q   <= bus.lsu_bus_rsp_err;
                ecc_q   <= bus.lsu_bus_rsp_ecc_err;
            end
        end
    end

    // Next-state logic and per-state pulse outputs
    always_comb begin
        state_d               = state_q;
        cap_e                 = 1'b0;
        cap_rsp               = 1'b0;
        req_valid             = 1'b0;
        lsu_except_ale_ls1    = 1'b0;
        lsu_except_buserr_ls3 = 1'b0;
        lsu_except_ecc_ls3    = 1'b0;
        lsu_data_valid_ls3    = 1'b0;
        lsu_wr_fin_ls3        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Responses arriving here are simply not looked at.
                if (lsu_vld_e) begin
                    cap_e   = 1'b1;
                    state_d = ST_LS1;
                end
            end
            ST_LS1: begin
                if (ale_w) begin
                    lsu_except_ale_ls1 = 1'b1;
                    state_d            = ST_IDLE;
                end else begin
                    req_valid = 1'b1;
                    if (bus.lsu_bus_req_ready) state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (bus.lsu_bus_rsp_valid) begin
                    cap_rsp = 1'b1;
                    state_d = ST_LS3;
                end
            end
            ST_LS3: begin
                state_d = ST_IDLE;
                if (err_q)                   lsu_except_buserr_ls3 = 1'b1;
                else if (!is_store && ecc_q) lsu_except_ecc_ls3    = 1'b1;
                else if (!is_store)          lsu_data_valid_ls3    = 1'b1;
                else                         lsu_wr_fin_ls3        = 1'b1;
            end
        endcase
    end

    // Request fields are held from latched registers and zeroed when idle
    assign bus.lsu_bus_req_valid = req_valid;
    assign bus.lsu_bus_req_we    = req_valid & is_store;
    assign bus.lsu_bus_req_addr  = req_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.lsu_bus_req_wstrb = (req_valid && is_store) ? strb_w : 4'b0000;
    assign bus.lsu_bus_req_wdata = (req_valid && is_store) ? lane_wdata_w : '0;
    assign lsu_rdata_ls3         = lsu_data_valid_ls3 ? ext_rdata_w : '0;

    // A new op while one is in flight breaks the ECL stall protocol
    a_vld_only_idle: assert property (
        @(posedge clk) disable iff (!resetn) lsu_vld_e |-> (state_q == ST_IDLE)
    );

endmodule

// File: tb/tb_c7bexu_lsu.sv
// Directed testbench for c7bexu_lsu: loads, stores, alignment exceptions,
// bus/ECC error priority, back-to-back ops and reset in mid-operation.
module tb_c7bexu_lsu;

    logic        clk = 1'b0;
    logic        resetn;
    logic        lsu_vld_e;
    logic [3:0]  lsu_op_e;
    logic [31:0] lsu_addr_e;
    logic [31:0] lsu_wdata_e;
    logic        lsu_except_ale_ls1, lsu_except_buserr_ls3, lsu_except_ecc_ls3;
    logic        lsu_data_valid_ls3, lsu_wr_fin_ls3;
    logic [31:0] lsu_rdata_ls3;
    logic [4:0]  status;

    int checks   = 0;
    int failures = 0;

    // Results captured by do_op
    logic [4:0]  o_status, o_post;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [3:0]  o_strb;
    logic        o_we, o_stable, o_req_seen, o_ale;

    c7bexu_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    c7bexu_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk                   (clk),
        .resetn                (resetn),
        .lsu_vld_e             (lsu_vld_e),
        .lsu_op_e              (lsu_op_e),
        .lsu_addr_e            (lsu_addr_e),
        .lsu_wdata_e           (lsu_wdata_e),
        .lsu_except_ale_ls1    (lsu_except_ale_ls1),
        .lsu_except_buserr_ls3 (lsu_except_buserr_ls3),
        .lsu_except_ecc_ls3    (lsu_except_ecc_ls3),
        .lsu_data_valid_ls3    (lsu_data_valid_ls3),
        .lsu_wr_fin_ls3        (lsu_wr_fin_ls3),
        .lsu_rdata_ls3         (lsu_rdata_ls3),
        .bus                   (bus_if)
    );

    always #5 clk = ~clk;

    // {ale, buserr, ecc, data_valid, wr_fin}
    assign status = {lsu_except_ale_ls1, lsu_except_buserr_ls3, lsu_except_ecc_ls3,
                     lsu_data_valid_ls3, lsu_wr_fin_ls3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one op with the bus model replying one cycle after acceptance.
    // Samples the LS1 request (or ALE), the LS3 pulse and the following idle cycle.
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input int ready_wait, input logic [31:0] rsp_rdata,
                         input logic err, input logic ecc);
        o_ale = 1'b0; o_req_seen = 1'b0; o_stable = 1'b1;
        o_status = '0; o_post = '0; o_rdata = '0;
        lsu_vld_e = 1'b1; lsu_op_e = op; lsu_addr_e = addr; lsu_wdata_e = wdata;
        tick();
        lsu_vld_e = 1'b0; lsu_op_e = '0; lsu_addr_e = '0; lsu_wdata_e = '0;
        if (lsu_except_ale_ls1) begin
            o_ale = 1'b1;
            o_status = status;
            o_req_seen = bus_if.lsu_bus_req_valid;
            tick();
            o_post = status;
            o_req_seen = o_req_seen | bus_if.lsu_bus_req_valid;
            return;
        end
        o_req_seen = bus_if.lsu_bus_req_valid;
        o_addr  = bus_if.lsu_bus_req_addr;
        o_strb  = bus_if.lsu_bus_req_wstrb;
        o_wdata = bus_if.lsu_bus_req_wdata;
        o_we    = bus_if.lsu_bus_req_we;
        for (int i = 0; i < ready_wait; i++) begin
            tick();
            if (!bus_if.lsu_bus_req_valid || bus_if.lsu_bus_req_addr !== o_addr ||
                bus_if.lsu_bus_req_wstrb !== o_strb || bus_if.lsu_bus_req_wdata !== o_wdata ||
                bus_if.lsu_bus_req_we !== o_we)
                o_stable = 1'b0;
        end
        bus_if.lsu_bus_req_ready = 1'b1;
        tick();
        bus_if.lsu_bus_req_ready = 1'b0;
        bus_if.lsu_bus_rsp_valid = 1'b1;
        bus_if.lsu_bus_rsp_rdata = rsp_rdata;
        bus_if.lsu_bus_rsp_err = err;
        bus_if.lsu_bus_rsp_ecc_err = ecc;
        tick();
        bus_if.lsu_bus_rsp_valid = 1'b0;
        bus_if.lsu_bus_rsp_rdata = '0;
        bus_if.lsu_bus_rsp_err = 1'b0;
        bus_if.lsu_bus_rsp_ecc_err = 1'b0;
        o_status = status;
        o_rdata = lsu_rdata_ls3;
        tick();
        o_post = status;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) tick();
        checks++;
        if (status !== 5'b0 || lsu_rdata_ls3 !== 32'd0) begin
            failures++;
            $display("FAIL reset_status: got %b/%h expected 00000/00000000", status, lsu_rdata_ls3);
        end
        checks++;
        if (bus_if.lsu_bus_req_valid !== 1'b0 || bus_if.lsu_bus_req_addr !== 32'd0 ||
            bus_if.lsu_bus_req_wstrb !== 4'd0 || bus_if.lsu_bus_req_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_bus: got v=%b a=%h s=%b d=%h expected all zero",
                     bus_if.lsu_bus_req_valid, bus_if.lsu_bus_req_addr,
                     bus_if.lsu_bus_req_wstrb, bus_if.lsu_bus_req_wdata);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (status !== 5'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got %b expected 00000", status);
        end
    endtask

    task automatic test_word_load();
        do_op(4'b0010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
        checks++;
        if (o_req_seen !== 1'b1 || o_addr !== 32'h100 || o_strb !== 4'b0 || o_we !== 1'b0) begin
            failures++;
            $display("FAIL wload_req: got v=%b a=%h s=%b we=%b expected 1/00000100/0000/0",
                     o_req_seen, o_addr, o_strb, o_we);
        end
        checks++;
        if (o_status !== 5'b00010 || o_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wload_ls3: got %b/%h expected 00010/deadbeef", o_status, o_rdata);
        end
        checks++;
        if (o_post !== 5'b0 || lsu_rdata_ls3 !== 32'd0) begin
            failures++;
            $display("FAIL wload_single_pulse: got %b/%h expected 00000/00000000", o_post, lsu_rdata_ls3);
        end
    endtask

    task automatic test_load_extract();
        logic [3:0]  ops [5]  = '{4'b0000, 4'b0101, 4'b0001, 4'b0100, 4'b0000};
        logic [31:0] adrs [5] = '{32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
        logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00008012, 32'hFFFF8012, 32'h00000034, 32'h00000056};
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], adrs[i], 32'h0, 0, 32'h80123456, 1'b0, 1'b0);
            checks++;
            if (o_status !== 5'b00010 || o_rdata !== exps[i] || o_addr !== 32'h100) begin
                failures++;
                $display("FAIL load_extract[%0d]: got %b/%h addr %h expected 00010/%h addr 00000100",
                         i, o_status, o_rdata, o_addr, exps[i]);
            end
        end
    endtask

    task automatic test_ale();
        logic [3:0]  ops [3]  = '{4'b0001, 4'b1010, 4'b0011};
        logic [31:0] adrs [3] = '{32'h101, 32'h102, 32'h100};
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], adrs[i], 32'h0, 0, 32'h0, 1'b0, 1'b0);
            checks++;
            if (o_ale !== 1'b1 || o_status !== 5'b10000 || o_req_seen !== 1'b0 || o_post !== 5'b0) begin
                failures++;
                $display("FAIL ale[%0d]: got ale=%b st=%b req=%b post=%b expected 1/10000/0/00000",
                         i, o_ale, o_status, o_req_seen, o_post);
            end
        end
        // Accepting an op in the cycle right after the ALE pulse
        do_op(4'b0010, 32'h300, 32'h0, 0, 32'h01020304, 1'b0, 1'b0);
        checks++;
        if (o_req_seen !== 1'b1 || o_status !== 5'b00010 || o_rdata !== 32'h01020304) begin
            failures++;
            $display("FAIL ale_then_load: got req=%b st=%b d=%h expected 1/00010/01020304",
                     o_req_seen, o_status, o_rdata);
        end
    endtask

    task automatic test_stores();
        logic [3:0]  ops [3]   = '{4'b1000, 4'b1001, 4'b1010};
        logic [31:0] adrs [3]  = '{32'h202, 32'h202, 32'h204};
        logic [31:0] wd [3]    = '{32'h000000A5, 32'h00001234, 32'h11223344};
        int          waits [3] = '{3, 1, 0};
        logic [31:0] ea [3]    = '{32'h200, 32'h200, 32'h204};
        logic [3:0]  es [3]    = '{4'b0100, 4'b1100, 4'b1111};
        logic [31:0] ed [3]    = '{32'hA5A5A5A5, 32'h12341234, 32'h11223344};
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], adrs[i], wd[i], waits[i], 32'h0, 1'b0, 1'b0);
            checks++;
            if (o_we !== 1'b1 || o_addr !== ea[i] || o_strb !== es[i] || o_wdata !== ed[i] || o_stable !== 1'b1) begin
                failures++;
                $display("FAIL store_req[%0d]: got we=%b a=%h s=%b d=%h stable=%b expected 1/%h/%b/%h/1",
                         i, o_we, o_addr, o_strb, o_wdata, o_stable, ea[i], es[i], ed[i]);
            end
            checks++;
            if (o_status !== 5'b00001 || o_rdata !== 32'd0 || o_post !== 5'b0) begin
                failures++;
                $display("FAIL store_fin[%0d]: got %b/%h post %b expected 00001/00000000 post 00000",
                         i, o_status, o_rdata, o_post);
            end
        end
    endtask

    task automatic test_errors();
        do_op(4'b0010, 32'h400, 32'h0, 0, 32'hCAFEF00D, 1'b1, 1'b1);
        checks++;
        if (o_status !== 5'b01000 || o_rdata !== 32'd0) begin
            failures++;
            $display("FAIL load_err_ecc: got %b/%h expected 01000/00000000", o_status, o_rdata);
        end
        do_op(4'b0010, 32'h404, 32'h0, 0, 32'hCAFEF00D, 1'b0, 1'b1);
        checks++;
        if (o_status !== 5'b00100 || o_rdata !== 32'd0) begin
            failures++;
            $display("FAIL load_ecc: got %b/%h expected 00100/00000000", o_status, o_rdata);
        end
        do_op(4'b1010, 32'h408, 32'h55AA55AA, 0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (o_status !== 5'b00001) begin
            failures++;
            $display("FAIL store_ecc: got %b expected 00001", o_status);
        end
        do_op(4'b1000, 32'h409, 32'h7E, 0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (o_status !== 5'b01000) begin
            failures++;
            $display("FAIL store_err: got %b expected 01000", o_status);
        end
    endtask

    task automatic test_reset_mid_op();
        lsu_vld_e = 1'b1; lsu_op_e = 4'b0010; lsu_addr_e = 32'h500;
        tick();
        lsu_vld_e = 1'b0; lsu_op_e = '0; lsu_addr_e = '0;
        bus_if.lsu_bus_req_ready = 1'b1;
        tick();
        bus_if.lsu_bus_req_ready = 1'b0;
        // In RSP now: reset asynchronously, away from the clock edge
        resetn = 1'b0;
        #1;
        checks++;
        if (status !== 5'b0 || lsu_rdata_ls3 !== 32'd0 || bus_if.lsu_bus_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_rsp: got %b/%h v=%b expected 00000/00000000 v=0",
                     status, lsu_rdata_ls3, bus_if.lsu_bus_req_valid);
        end
        tick();
        resetn = 1'b1;
        bus_if.lsu_bus_rsp_valid = 1'b1;
        bus_if.lsu_bus_rsp_rdata = 32'h12345678;
        tick();
        bus_if.lsu_bus_rsp_valid = 1'b0;
        bus_if.lsu_bus_rsp_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (status !== 5'b0 || bus_if.lsu_bus_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL stray_rsp[%0d]: got %b v=%b expected 00000 v=0",
                         i, status, bus_if.lsu_bus_req_valid);
            end
            tick();
        end
        do_op(4'b0010, 32'h600, 32'h0, 0, 32'hA0B0C0D0, 1'b0, 1'b0);
        checks++;
        if (o_status !== 5'b00010 || o_rdata !== 32'hA0B0C0D0) begin
            failures++;
            $display("FAIL recover_load: got %b/%h expected 00010/a0b0c0d0", o_status, o_rdata);
        end
    endtask

    initial begin
        resetn = 1'b0;
        lsu_vld_e = 1'b0; lsu_op_e = '0; lsu_addr_e = '0; lsu_wdata_e = '0;
        bus_if.lsu_bus_req_ready = 1'b0;
        bus_if.lsu_bus_rsp_valid = 1'b0;
        bus_if.lsu_bus_rsp_rdata = '0;
        bus_if.lsu_bus_rsp_err = 1'b0;
        bus_if.lsu_bus_rsp_ecc_err = 1'b0;
        test_reset();
        test_word_load();
        test_load_extract();
        test_ale();
        test_stores();
        test_errors();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
